handshake_constant_arbiter: RTL and testbench

- Shares one constant-producing output channel among NUM_REQ control-token requesters.
- Each requester has its own constant, taken from a parameter table. A granted control token emits that constant, tagged with the requester index.
- Round-robin arbitration; the output is registered with a one-slot, full-throughput elastic stage.
- Sits where several dataflow basic blocks need constants routed to a single shared consumer, such as a shared functional unit or memory port.

---
 rtl/handshake_constant_arbiter.sv | 125 ++++++++++++
 tb/tb_handshake_constant_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/handshake_constant_arbiter.sv
// handshake_constant_arbiter
// Round-robin arbiter that routes per-requester constants from a parameter
// table onto one shared output channel. A one-slot elastic output register
// supports a full-throughput load and consume in the same cycle.
//
// Handshake rule (both sides): a token moves on a rising edge exactly when
// valid and ready are both high at that edge. A producer may drop valid
// without a handshake. The output channel keeps outs and outs_index stable
// while outs_valid=1 and outs_ready=0. ctrl_ready depends combinationally
// only on ctrl_valid, outs_ready and rst.
module handshake_constant_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter logic [DATA_WIDTH*NUM_REQ-1:0] CONST_TABLE =
    128'h000000C8_00000064_0000000A_00000001,
  localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_WIDTH-1:0]  outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  // The output register is the only FSM; outs_valid is its state bit.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [IDX_WIDTH-1:0]   ptr;
  logic [IDX_WIDTH-1:0]   ptr_next;
  logic [IDX_WIDTH-1:0]   grant_idx;
  logic                   grant_valid;
  logic                   load_en;
  logic                   transfer;
  logic [DATA_WIDTH-1:0]  const_rom [NUM_REQ];

  // Unpack the flattened constant table into one entry per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rom
    assign const_rom[gi] = CONST_TABLE[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // The register can accept a token when empty or when its token leaves now.
  assign load_en    = (state == EMPTY) | outs_ready;
  assign outs_valid = (state == FULL);

  // Search ctrl_valid from ptr upward, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    int                   cand;
    logic [IDX_WIDTH-1:0] cand_idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = cand[IDX_WIDTH-1:0];
      if (!grant_valid && ctrl_valid[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // One-hot ready toward the granted requester; nothing is granted in reset.
  always_comb begin
    ctrl_ready = '0;
    if (load_en && grant_valid && rst) begin
      ctrl_ready[grant_idx] = 1'b1;
    end
  end

  assign transfer = |(ctrl_valid & ctrl_ready);

  // Priority moves to the requester just after the one that was served.
  always_comb begin
    if (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + 1'b1;
    end
  end

  // Output register state: fill on a transfer, drain on a consume, else hold.
  always_comb begin
    state_next = state;
    if (transfer) begin
      state_next = FULL;
    end else if (outs_ready) begin
      state_next = EMPTY;
    end
  end

  // State register; reset drops any token held in the output slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Payload and priority pointer change only when a token is loaded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outs       <= '0;
      outs_index <= '0;
      ptr        <= '0;
    end else if (transfer) begin
      outs       <= const_rom[grant_idx];
      outs_index <= grant_idx;
      ptr        <= ptr_next;
    end
  end

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Directed bench for handshake_constant_arbiter with default parameters
// (NUM_REQ=4, constants 1, 10, 100, 200).
module tb_handshake_constant_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  ctrl_valid;
  logic [3:0]  ctrl_ready;
  logic [31:0] outs;
  logic [1:0]  outs_index;
  logic        outs_valid;
  logic        outs_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] const_tbl [4];

  handshake_constant_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_index (outs_index),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs and let combinational outputs settle.
  task automatic drive(input logic r, input logic [3:0] cv, input logic ordy);
    rst        = r;
    ctrl_valid = cv;
    outs_ready = ordy;
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp_data,
                           input logic [1:0] exp_idx, input logic exp_valid);
    check({tag, "_outs"}, outs, exp_data);
    check({tag, "_index"}, 32'(outs_index), 32'(exp_idx));
    check({tag, "_valid"}, 32'(outs_valid), 32'(exp_valid));
  endtask

  initial begin
    const_tbl[0] = 32'd1;
    const_tbl[1] = 32'd10;
    const_tbl[2] = 32'd100;
    const_tbl[3] = 32'd200;

    // Reset with every requester valid.
    drive(1'b0, 4'b1111, 1'b1);
    tick();
    tick();
    check("rst_ready", 32'(ctrl_ready), 32'b0000);
    check_out("rst", 32'd0, 2'd0, 1'b0);

    // Release: requester 0 is granted first.
    drive(1'b1, 4'b1111, 1'b1);
    check("rel_ready", 32'(ctrl_ready), 32'b0001);
    tick();
    check_out("rel", 32'd1, 2'd0, 1'b1);

    // Single requester 2 for three cycles (ptr 1 -> 3).
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'b0100, 1'b1);
      check("single_ready", 32'(ctrl_ready), 32'b0100);
      tick();
      check_out("single", 32'd100, 2'd2, 1'b1);
    end

    // ptr is now 3: with all valid, requester 3 goes first.
    drive(1'b1, 4'b1111, 1'b1);
    check("ptr3_ready", 32'(ctrl_ready), 32'b1000);
    tick();
    check_out("ptr3", 32'd200, 2'd3, 1'b1);

    // All contend: 0,1,2,3,0,1 back to back with no bubbles.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 4'b1111, 1'b1);
      check("rr_ready", 32'(ctrl_ready), 32'(4'b0001 << (k % 4)));
      tick();
      check_out("rr", const_tbl[k % 4], 2'(k % 4), 1'b1);
    end

    // Backpressure: requester 1 token stalls, nothing else granted (ptr=2).
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'b1111, 1'b0);
      check("bp_ready", 32'(ctrl_ready), 32'b0000);
      tick();
      check_out("bp", 32'd10, 2'd1, 1'b1);
    end
    drive(1'b1, 4'b1111, 1'b1);
    check("bp_release_ready", 32'(ctrl_ready), 32'b0100);
    tick();
    check_out("bp_release", 32'd100, 2'd2, 1'b1);

    // ptr=3: serve requester 0 alone to move ptr to 1.
    drive(1'b1, 4'b0001, 1'b1);
    check("to_ptr1_ready", 32'(ctrl_ready), 32'b0001);
    tick();
    check_out("to_ptr1", 32'd1, 2'd0, 1'b1);

    // Skip: ptr=1 with 1001 grants 3, then 0.
    drive(1'b1, 4'b1001, 1'b1);
    check("skip_ready", 32'(ctrl_ready), 32'b1000);
    tick();
    check_out("skip", 32'd200, 2'd3, 1'b1);
    drive(1'b1, 4'b1001, 1'b1);
    check("fair_ready", 32'(ctrl_ready), 32'b0001);
    tick();
    check_out("fair", 32'd1, 2'd0, 1'b1);

    // ptr=1: requester 3 waits behind a stall, then withdraws ungranted.
    drive(1'b1, 4'b1000, 1'b0);
    check("wait_ready", 32'(ctrl_ready), 32'b0000);
    tick();
    check_out("wait", 32'd1, 2'd0, 1'b1);
    drive(1'b1, 4'b0000, 1'b1);
    check("drop_ready", 32'(ctrl_ready), 32'b0000);
    tick();
    check_out("drop", 32'd1, 2'd0, 1'b0);

    // Empty register accepts a token even while outs_ready=0 (ptr=1).
    drive(1'b1, 4'b0010, 1'b0);
    check("empty_load_ready", 32'(ctrl_ready), 32'b0010);
    tick();
    check_out("empty_load", 32'd10, 2'd1, 1'b1);

    // Move ptr to 3 with requester 2's token held under stall.
    drive(1'b1, 4'b0100, 1'b1);
    check("pre_rst_ready", 32'(ctrl_ready), 32'b0100);
    tick();
    drive(1'b1, 4'b1111, 1'b0);
    check("pre_rst_stall_ready", 32'(ctrl_ready), 32'b0000);
    check_out("pre_rst", 32'd100, 2'd2, 1'b1);

    // Mid-operation reset drops the token and clears ptr.
    drive(1'b0, 4'b1111, 1'b1);
    check("mid_rst_ready", 32'(ctrl_ready), 32'b0000);
    tick();
    check_out("mid_rst", 32'd0, 2'd0, 1'b0);
    drive(1'b1, 4'b1111, 1'b1);
    check("post_rst_ready", 32'(ctrl_ready), 32'b0001);
    tick();
    check_out("post_rst", 32'd1, 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
